// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Covers the hazards the forwarding unit cannot fix: load-use, branch
// operands compared in ID, and HI/LO reads while mult/div is busy.
// Optional build macro HAZ_PERF_CNT_EN adds the stall_cycles and
// flush_count performance counters.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IF_ID_rs,
    input  logic [4:0]        IF_ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_is_branch,
    input  logic              ID_uses_md,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              ID_EX_regwr,
    input  logic              ID_EX_memRd,
    input  logic [4:0]        ID_EX_regwrad,
    input  logic              EX_MEM_memRd,
    input  logic [4:0]        EX_MEM_regwrad,
    input  logic              md_start,
    input  logic              md_done,
    output logic              PC_wr,
    output logic              IF_ID_wr,
    output logic              IF_ID_flush,
    output logic              ID_EX_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
`endif
    output logic              md_timeout
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_MD_BUSY = 2'd2;

    localparam logic [7:0] MD_LIMIT   = 8'(MD_TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [1:0] stall_left_q, stall_left_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       md_timeout_q, md_timeout_d;

    logic       match_ex;
    logic       match_mem;
    logic [1:0] n_req;
    logic       stall;
    logic       flush;

    // Source-register match against the EX and MEM destinations ($zero never matches)
    always_comb begin
        match_ex  = (ID_EX_regwrad != 5'd0) &&
                    ((ID_EX_regwrad == IF_ID_rs && ID_uses_rs) ||
                     (ID_EX_regwrad == IF_ID_rt && ID_uses_rt));
        match_mem = (EX_MEM_regwrad != 5'd0) &&
                    ((EX_MEM_regwrad == IF_ID_rs && ID_uses_rs) ||
                     (EX_MEM_regwrad == IF_ID_rt && ID_uses_rt));
    end

    // Required stall count; earlier rules take precedence
    always_comb begin
        if (ID_is_branch && ID_EX_memRd && match_ex) begin
            n_req = 2'd2;
        end else if (ID_is_branch && ID_EX_regwr && match_ex) begin
            n_req = 2'd1;
        end else if (ID_is_branch && EX_MEM_memRd && match_mem) begin
            n_req = 2'd1;
        end else if (ID_EX_memRd && match_ex) begin
            n_req = 2'd1;
        end else begin
            n_req = 2'd0;
        end
    end

    // Stall/flush decision from the current state; reset forces a stall
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (reset) begin
            stall = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    stall = (n_req != 2'd0);
                    flush = (n_req == 2'd0) && (branch_taken || jump);
                end
                ST_MD_BUSY: begin
                    // md_done releases the HI/LO wait in the same cycle
                    if (ID_uses_md && !md_done) begin
                        stall = 1'b1;
                    end else begin
                        stall = (n_req != 2'd0);
                        flush = (n_req == 2'd0) && (branch_taken || jump);
                    end
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

    assign PC_wr        = ~stall;
    assign IF_ID_wr     = ~stall;
    assign ID_EX_bubble = stall;
    assign IF_ID_flush  = flush;
    assign md_timeout   = md_timeout_q;

    // Next-state logic for the FSM, the stall counter and the mult/div watchdog
    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;

        if (state_q == ST_MD_BUSY) begin
            if (md_cnt_q != 8'hFF) begin
                md_cnt_d = md_cnt_q + 8'd1;
            end
            if (md_cnt_q == MD_LIMIT) begin
                md_timeout_d = 1'b1;
            end
        end

        if (md_start) begin
            // A new mult/div overrides everything, including a pending branch stall
            state_d      = ST_MD_BUSY;
            md_cnt_d     = 8'd0;
            stall_left_d = 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (n_req == 2'd2) begin
                        state_d      = ST_STALL;
                        stall_left_d = 2'd1;
                    end
                end
                ST_STALL: begin
                    stall_left_d = stall_left_q - 2'd1;
                    if (stall_left_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d      = ST_RUN;
                    stall_left_d = 2'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            stall_left_q <= 2'd0;
            md_cnt_q     <= 8'd0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    // Free-running performance counters, wrapping at 2^PERF_W
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (flush) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
